// File: rtl/swervolf_sevenseg_pkg.sv
// Shared constants for the seven-segment scanner: segment codes, blanking value
// and default scan timing.
package swervolf_sevenseg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam int DEFAULT_DWELL_CYCLES = 65536;
    localparam int DEFAULT_BLANK_CYCLES = 64;

    // Active-low {g,f,e,d,c,b,a}; entry 15 is leftmost so SEG_TABLE[n] is digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/swervolf_sevenseg_scan.sv
// Dwell counter and digit index for the display scan, plus the end-of-scan
// snapshot strobe and its registered o_frame pulse.
module swervolf_sevenseg_scan
    import swervolf_sevenseg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
    localparam int CNT_W       = $clog2(DWELL_CYCLES),
    localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic [IDX_W-1:0] idx,
    output logic             snap_load,
    output logic             o_frame
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] idx_next;
    logic             frame_reg;
    logic             cnt_wrap;

    assign cnt_wrap  = (cnt_reg == CNT_LAST);
    // Last cycle of the last digit: the following edge starts a new scan.
    assign snap_load = cnt_wrap && (idx_reg == IDX_LAST);

    always_comb begin
        cnt_next = cnt_reg + CNT_W'(1);
        idx_next = idx_reg;
        if (cnt_wrap) begin
            cnt_next = '0;
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            frame_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            frame_reg <= snap_load;
        end
    end

    assign cnt     = cnt_reg;
    assign idx     = idx_reg;
    assign o_frame = frame_reg;

endmodule

// File: rtl/swervolf_sevenseg.sv
// Time-multiplexed seven-segment driver: per-scan input snapshot, blanking at
// the start of each dwell, 16-step PWM dimming and registered active-low outputs.
module swervolf_sevenseg
    import swervolf_sevenseg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic [DIGITS-1:0]     i_blank,
    input  logic [3:0]            i_brightness,
    output logic [DIGITS-1:0]     o_an,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic                  o_frame
);

    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                snap_load;

    logic [4*DIGITS-1:0] snap_value_reg;
    logic [DIGITS-1:0]   snap_dp_reg;
    logic [DIGITS-1:0]   snap_blank_reg;
    logic [3:0]          snap_brightness_reg;

    logic [3:0]          nibble [DIGITS];
    logic                active;
    logic [DIGITS-1:0]   an_next;
    logic [6:0]          seg_next;
    logic                dp_next;

    logic [DIGITS-1:0]   an_reg;
    logic [6:0]          seg_reg;
    logic                dp_reg;

    swervolf_sevenseg_scan #(
        .DIGITS       (DIGITS),
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt),
        .idx       (idx),
        .snap_load (snap_load),
        .o_frame   (o_frame)
    );

    // Inputs are only sampled between scans so a frame never shows a mix of old and new values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_value_reg      <= '0;
            snap_dp_reg         <= '0;
            snap_blank_reg      <= '0;
            snap_brightness_reg <= '0;
        end else if (snap_load) begin
            snap_value_reg      <= i_value;
            snap_dp_reg         <= i_dp;
            snap_blank_reg      <= i_blank;
            snap_brightness_reg <= i_brightness;
        end
    end

    // PWM phase is the low four bits of the dwell counter; brightness n lights n+1 of 16 cycles.
    assign active = (cnt >= BLANK_END) &&
                    (cnt[3:0] <= snap_brightness_reg) &&
                    !snap_blank_reg[idx];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nibble[gi]  = snap_value_reg[4*gi +: 4];
            assign an_next[gi] = ~(active && (idx == IDX_W'(gi)));
        end
    endgenerate

    always_comb begin
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        if (active) begin
            seg_next = hex_to_seg(nibble[idx]);
            dp_next  = ~snap_dp_reg[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_reg  <= '1;
            seg_reg <= SEG_OFF;
            dp_reg  <= 1'b1;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
        end
    end

    assign o_an  = an_reg;
    assign o_seg = seg_reg;
    assign o_dp  = dp_reg;

endmodule

// File: tb/tb_swervolf_sevenseg.sv
// Scoreboard bench for swervolf_sevenseg: a cycle-count reference model queues the
// expected outputs per clock, a monitor pops and compares them on the falling edge.
module tb_swervolf_sevenseg;

    localparam int DIGITS = 8;
    localparam int DWELL  = 32;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * DWELL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] value = '0;
    logic [7:0]  dp = '0;
    logic [7:0]  blank = '0;
    logic [3:0]  bright = '0;
    logic [7:0]  o_an;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic        o_frame;

    always #5 clk = ~clk;

    swervolf_sevenseg #(
        .DIGITS       (DIGITS),
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_value      (value),
        .i_dp         (dp),
        .i_blank      (blank),
        .i_brightness (bright),
        .o_an         (o_an),
        .o_seg        (o_seg),
        .o_dp         (o_dp),
        .o_frame      (o_frame)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   frames_seen = 0;

    logic [6:0] hex_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: time since reset decides digit and phase; snapshot is the input set seen at each scan end.
    int unsigned t = 0;
    logic [31:0] m_value = '0;
    logic [7:0]  m_dp = '0;
    logic [7:0]  m_blank = '0;
    logic [3:0]  m_bright = '0;

    always @(posedge clk or posedge rst) begin
        int   cnt;
        int   idx;
        bit   on;
        obs_t e;
        if (rst) begin
            t = 0;
            m_value = '0;
            m_dp = '0;
            m_blank = '0;
            m_bright = '0;
            exp_q.delete();
        end else begin
            cnt = int'(t % DWELL);
            idx = int'((t / DWELL) % DIGITS);
            on  = (cnt >= BLANK) && ((cnt % 16) <= int'(m_bright)) && !m_blank[idx];
            e.an    = on ? ~(8'h01 << idx) : 8'hFF;
            e.seg   = on ? hex_ref[m_value[4*idx +: 4]] : 7'h7F;
            e.dp    = on ? ~m_dp[idx] : 1'b1;
            e.frame = (t % FRAME) == (FRAME - 1);
            exp_q.push_back(e);
            if (e.frame) begin
                m_value  = value;
                m_dp     = dp;
                m_blank  = blank;
                m_bright = bright;
            end
            t++;
        end
    end

    // Monitor: compare one queued expectation per cycle, plus one-hot anodes and frame period.
    int since_frame = -1;
    always @(negedge clk) begin
        obs_t e;
        obs_t got;
        if (rst) begin
            since_frame = -1;
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {o_an, o_seg, o_dp, o_frame};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL outputs: got an=%h seg=%h dp=%b frame=%b want an=%h seg=%h dp=%b frame=%b at %0t",
                             got.an, got.seg, got.dp, got.frame, e.an, e.seg, e.dp, e.frame, $time);
                end
            end
            chk("one_anode", 32'($countones(~o_an) <= 1), 32'd1);
            if (since_frame >= 0) since_frame++;
            if (o_frame) begin
                if (since_frame >= 0) chk("frame_period", 32'(since_frame), 32'(FRAME));
                since_frame = 0;
                frames_seen++;
                $display("frame %0d at %0t: value=%h dp=%h blank=%h bright=%0d",
                         frames_seen, $time, value, dp, blank, bright);
            end
        end
    end

    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4 * FRAME && !seen; i++) begin
            @(negedge clk);
            if (o_frame) seen = 1'b1;
        end
        chk("frame_timeout", 32'(seen), 32'd1);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_an"},  32'(o_an),  32'hFF);
        chk({name, "_seg"}, 32'(o_seg), 32'h7F);
        chk({name, "_dp"},  32'(o_dp),  32'd1);
        chk({name, "_frm"}, 32'(o_frame), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        // Plain hex pattern, full brightness.
        value  = 32'h01234567;
        bright = 4'd15;
        wait_frame();
        repeat (3) @(negedge clk);
        chk("dig0_an",  32'(o_an),  32'hFE);
        chk("dig0_seg", 32'(o_seg), 32'h78);
        repeat (7 * DWELL) @(negedge clk);
        chk("dig7_an",  32'(o_an),  32'h7F);
        chk("dig7_seg", 32'(o_seg), 32'h40);

        // Input change mid-scan must not tear the frame.
        wait_frame();
        repeat (3 * DWELL + 10) @(negedge clk);
        value = 32'h88888888;
        wait_frame();
        chk("tear_dig7", 32'(o_seg), 32'h40);
        repeat (3) @(negedge clk);
        chk("new_dig0", 32'(o_seg), 32'h00);

        // Blanked digits and decimal point.
        blank = 8'h0F;
        dp    = 8'h10;
        wait_frame();
        wait_frame();

        // Dimmed brightness levels.
        blank  = 8'h00;
        bright = 4'd3;
        wait_frame();
        bright = 4'd0;
        wait_frame();
        wait_frame();

        // Asynchronous reset mid-dwell while a digit is lit.
        value  = 32'hDEADBEEF;
        bright = 4'd15;
        wait_frame();
        repeat (3 * DWELL + 20) @(negedge clk);
        chk("pre_rst_lit", 32'(o_an == 8'hFF), 32'd0);
        #2 rst = 1'b1;
        #1 chk_reset("async_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Randomized inputs.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            value  = $urandom;
            dp     = 8'($urandom);
            blank  = 8'($urandom_range(0, 3) == 0 ? $urandom : 0);
            bright = 4'($urandom);
        end
        repeat (4) @(negedge clk);

        chk("frames_seen", 32'(frames_seen > 40), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
